// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//
// Memory side of the CPU inst/data SRAM interface. Accepts one request per
// cycle (read, or byte-masked write). Read data comes back RD_LATENCY cycles
// later with a one-cycle sram_rvalid strobe. Accesses outside the window
// [ADDR_BASE, ADDR_BASE + 4*2^DEPTH_LOG2) are flagged on sram_err.
//
// Parameters:
//   ADDR_BASE   byte address of word 0
//   DEPTH_LOG2  log2 of the number of 32-bit words
//   RD_LATENCY  request-to-rvalid latency, 1..4
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   sram_en     request valid this cycle
//   sram_we     byte-lane write enables (0 with sram_en = read)
//   sram_addr   byte address, bits [1:0] ignored
//   sram_wdata  write data, lane i = bits [8i+7:8i]
//   sram_rdata  registered read data, holds between reads
//   sram_rvalid one-cycle pulse, sram_rdata valid
//   sram_err    one-cycle pulse, out-of-window access
//   rd_cnt      (SRAM_ACCESS_CNT_EN only) in-range reads accepted
//   wr_cnt      (SRAM_ACCESS_CNT_EN only) in-range writes accepted
//
// Optional feature macro: SRAM_ACCESS_CNT_EN adds the rd_cnt/wr_cnt counters.
// ---------------------------------------------------------------------------
module sram_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h1c00_0000,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        sram_rvalid,
  output logic        sram_err
`ifdef SRAM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("sram_responder: RD_LATENCY must be in 1..4");
    end
  endgenerate

  localparam int          WORDS     = 1 << DEPTH_LOG2;
  // 33 bits so the window size cannot overflow for large DEPTH_LOG2.
  localparam logic [32:0] WIN_BYTES = 33'd4 << DEPTH_LOG2;

  // -------------------------------------------------------------------------
  // Address decode. An address below ADDR_BASE underflows off to a huge
  // value; the explicit >= check keeps it out of range rather than aliased.
  // -------------------------------------------------------------------------
  logic [31:0]           off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] widx;

  assign off      = sram_addr - ADDR_BASE;
  assign in_range = (sram_addr >= ADDR_BASE) && ({1'b0, off} < WIN_BYTES);
  assign widx     = off[DEPTH_LOG2+1:2];

  // Requests seen while reset is high are ignored entirely.
  logic accept, rd_fire, wr_fire;
  assign accept  = sram_en && !reset;
  assign rd_fire = accept && (sram_we == 4'b0000);
  assign wr_fire = accept && (sram_we != 4'b0000);

  // -------------------------------------------------------------------------
  // Storage, not reset.
  // -------------------------------------------------------------------------
  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (wr_fire && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) mem_q[widx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read pipeline. Stage 0 captures at the request edge, so a 1-cycle read
  // sees the word as of the end of the request cycle (and therefore a write
  // from the previous cycle). Data stages only load when the stage feeding
  // them is valid, so the last stage, which is sram_rdata, holds its value
  // between reads.
  // -------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] vld_q, err_q;
  logic [31:0]           data_q [RD_LATENCY];
  logic                  vld_d, err_d;
  logic [31:0]           data_d;

  always_comb begin
    vld_d  = rd_fire;
    err_d  = rd_fire && !in_range;
    data_d = in_range ? mem_q[widx] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= 32'h0;
    end else begin
      vld_q[0] <= vld_d;
      err_q[0] <= err_d;
      if (vld_d) data_q[0] <= data_d;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Write errors report one cycle after the request regardless of the read
  // latency; a coincident read error merges into the same pulse.
  // -------------------------------------------------------------------------
  logic wr_err_q, wr_err_d;

  assign wr_err_d = wr_fire && !in_range;

  always_ff @(posedge clk) begin
    if (reset) wr_err_q <= 1'b0;
    else       wr_err_q <= wr_err_d;
  end

  assign sram_rvalid = vld_q[RD_LATENCY-1];
  assign sram_rdata  = data_q[RD_LATENCY-1];
  assign sram_err    = (vld_q[RD_LATENCY-1] & err_q[RD_LATENCY-1]) | wr_err_q;

`ifdef SRAM_ACCESS_CNT_EN
  // -------------------------------------------------------------------------
  // Access counters: in-range accepted requests only, wrap mod 2^32.
  // -------------------------------------------------------------------------
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_fire && in_range) rd_cnt_d = rd_cnt_q + 32'd1;
    if (wr_fire && in_range) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  // Access counters not built.
`endif

endmodule
